cpld_xnor_match: RTL and testbench



---
 rtl/cpld_xnor_match_pkg.sv | 17 +
 rtl/cpld_xnor_cmp.sv | 24 ++
 rtl/cpld_xnor_match.sv | 129 ++++++++++++
 tb/tb_cpld_xnor_match.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpld_xnor_match_pkg.sv
// Shared types and constants for the serial XNOR pattern detector.
// The detector FSM state and the default window/counter widths live here.
package cpld_xnor_match_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CW    = 4;

   // Hit counter ceiling for the default counter width.
   localparam logic [DEF_CW-1:0] HCNT_SAT = DEF_CW'((1 << DEF_CW) - 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ARMED = 2'd1,
      HIT   = 2'd2
   } state_e;

endpackage

// File: rtl/cpld_xnor_cmp.sv
// Combinational compare stage: per-bit XNOR of window against pattern,
// then a masked AND-reduction (masked-off bits always count as equal).
module cpld_xnor_cmp #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] sr_i,
   input  logic [WIDTH-1:0] pr_i,
   input  logic [WIDTH-1:0] mr_i,
   output logic [WIDTH-1:0] zn_o,
   output logic             eq_o
);

   logic [WIDTH-1:0] bit_ok;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign zn_o[gi]   = sr_i[gi] ~^ pr_i[gi];
         assign bit_ok[gi] = zn_o[gi] | ~mr_i[gi];
      end
   endgenerate

   assign eq_o = &bit_ok;

endmodule

// File: rtl/cpld_xnor_match.sv
// Serial-in programmable pattern detector: shift window, masked compare,
// acknowledged MATCH event with sticky overrun and saturating hit count.
module cpld_xnor_match
   import cpld_xnor_match_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CW    = DEF_CW
) (
   input  logic             CK,
   input  logic             CDN,
   input  logic             SI,
   input  logic             SE,
   input  logic             LD,
   input  logic [WIDTH-1:0] PAT,
   input  logic [WIDTH-1:0] MSK,
   input  logic             ACK,
   output logic             RDY,
   output logic             MATCH,
   output logic [CW-1:0]    HCNT,
   output logic             OVR,
   output logic [WIDTH-1:0] ZN
);

   localparam int             FCW      = $clog2(WIDTH + 1);
   localparam logic [FCW-1:0] FC_FULL  = FCW'(WIDTH);
   localparam logic [FCW-1:0] FC_LAST  = FCW'(WIDTH - 1);
   localparam logic [CW-1:0]  HCNT_MAX = '1;

   logic [WIDTH-1:0] sr_q, pr_q, mr_q, zn_q;
   logic [WIDTH-1:0] sr_d;
   logic [FCW-1:0]   fc_q, fc_d;
   logic             new_q, new_d;
   logic             match_q, ovr_q;
   logic [CW-1:0]    hcnt_q, hcnt_sat;
   state_e           state_q;

   logic [WIDTH-1:0] zn_raw;
   logic             eq;
   logic             hit_now;

   cpld_xnor_cmp #(.WIDTH(WIDTH)) u_cmp (
      .sr_i (sr_q),
      .pr_i (pr_q),
      .mr_i (mr_q),
      .zn_o (zn_raw),
      .eq_o (eq)
   );

   // A window is judged once: NEW drops after evaluation unless a shift refills it.
   always_comb begin
      sr_d  = sr_q;
      fc_d  = fc_q;
      new_d = new_q;
      if (LD) begin
         sr_d  = '0;
         fc_d  = '0;
         new_d = 1'b0;
      end else if (SE) begin
         sr_d  = {sr_q[WIDTH-2:0], SI};
         fc_d  = (fc_q == FC_FULL) ? fc_q : fc_q + FCW'(1);
         new_d = 1'b1;
      end else if (state_q != FILL) begin
         new_d = 1'b0;
      end
   end

   assign hit_now  = (state_q != FILL) && new_q && eq;
   assign hcnt_sat = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + CW'(1);

   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         sr_q    <= '0;
         pr_q    <= '0;
         mr_q    <= '1;
         fc_q    <= '0;
         new_q   <= 1'b0;
         zn_q    <= '1;
         state_q <= FILL;
         match_q <= 1'b0;
         hcnt_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         fc_q  <= fc_d;
         new_q <= new_d;
         zn_q  <= zn_raw;
         if (LD) begin
            pr_q    <= PAT;
            mr_q    <= MSK;
            state_q <= FILL;
            match_q <= 1'b0;
         end else begin
            case (state_q)
               FILL: begin
                  if (SE && fc_q == FC_LAST) state_q <= ARMED;
               end
               ARMED: begin
                  if (hit_now) begin
                     state_q <= HIT;
                     match_q <= 1'b1;
                     hcnt_q  <= hcnt_sat;
                  end
               end
               HIT: begin
                  // A fresh match outranks ACK: the acknowledged event is replaced by the new one.
                  if (hit_now) begin
                     hcnt_q <= hcnt_sat;
                     if (!ACK) ovr_q <= 1'b1;
                  end else if (ACK) begin
                     state_q <= ARMED;
                     match_q <= 1'b0;
                  end
               end
               default: begin
                  state_q <= FILL;
                  match_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign RDY   = (state_q != FILL);
   assign MATCH = match_q;
   assign HCNT  = hcnt_q;
   assign OVR   = ovr_q;
   assign ZN    = zn_q;

endmodule

// File: tb/tb_cpld_xnor_match.sv
// Directed bench for cpld_xnor_match: fill, mask, ACK handshake, overrun,
// back-to-back with ACK held, LD/SE priority and asynchronous reset.
module tb_cpld_xnor_match;
   import cpld_xnor_match_pkg::*;

   logic       CK = 1'b0;
   logic       CDN, SI, SE, LD, ACK;
   logic [7:0] PAT, MSK;
   logic       RDY, MATCH, OVR;
   logic [3:0] HCNT;
   logic [7:0] ZN;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   cpld_xnor_match #(.WIDTH(8), .CW(4)) dut (
      .CK    (CK),
      .CDN   (CDN),
      .SI    (SI),
      .SE    (SE),
      .LD    (LD),
      .PAT   (PAT),
      .MSK   (MSK),
      .ACK   (ACK),
      .RDY   (RDY),
      .MATCH (MATCH),
      .HCNT  (HCNT),
      .OVR   (OVR),
      .ZN    (ZN)
   );

   always #5 CK = ~CK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
         $display("ok   %s: got %0h", tag, obs);
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      @(negedge CK);
   endtask

   task automatic load(input logic [7:0] p, input logic [7:0] m);
      LD = 1'b1; PAT = p; MSK = m;
      tick();
      LD = 1'b0;
   endtask

   task automatic shift_byte(input logic [7:0] v, input string tag);
      for (int i = 7; i >= 0; i--) begin
         SE = 1'b1; SI = v[i];
         tick();
         if (i == 1) check({tag, "_rdy_7th"}, 32'(RDY), 32'd0);
      end
      SE = 1'b0;
      check({tag, "_rdy_8th"}, 32'(RDY), 32'd1);
      check({tag, "_match_pre"}, 32'(MATCH), 32'd0);
   endtask

   initial begin
      CDN = 1'b0; SI = 1'b0; SE = 1'b0; LD = 1'b0; ACK = 1'b0;
      PAT = 8'h00; MSK = 8'h00;

      // Reset values
      #12;
      check("rst_rdy",   32'(RDY),   32'd0);
      check("rst_match", 32'(MATCH), 32'd0);
      check("rst_hcnt",  32'(HCNT),  32'd0);
      check("rst_ovr",   32'(OVR),   32'd0);
      check("rst_mr",    32'(dut.mr_q), 32'hFF);
      CDN = 1'b1;
      tick();
      check("rst_zn", 32'(ZN), 32'hFF);
      check("rst_rdy2", 32'(RDY), 32'd0);

      // Fill with A5, full mask
      load(8'hA5, 8'hFF);
      shift_byte(8'hA5, "fill");
      tick();
      check("fill_match", 32'(MATCH), 32'd1);
      check("fill_hcnt",  32'(HCNT),  32'd1);
      check("fill_zn",    32'(ZN),    32'hFF);

      // LD with SE together mid-stream, new masked pattern
      LD = 1'b1; SE = 1'b1; SI = 1'b1; PAT = 8'hF0; MSK = 8'hF0;
      tick();
      LD = 1'b0; SE = 1'b0;
      check("ld_sr",    32'(dut.sr_q), 32'h00);
      check("ld_fc",    32'(dut.fc_q), 32'd0);
      check("ld_rdy",   32'(RDY),   32'd0);
      check("ld_hcnt",  32'(HCNT),  32'd1);
      check("ld_match", 32'(MATCH), 32'd0);
      shift_byte(8'hF6, "mask");
      tick();
      check("mask_match", 32'(MATCH), 32'd1);
      check("mask_hcnt",  32'(HCNT),  32'd2);
      check("mask_zn",    32'(ZN),    32'hF9);

      // ACK handshake
      ACK = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ack_hold_match", 32'(MATCH), 32'd1);
      end
      ACK = 1'b1;
      tick();
      check("ack_match", 32'(MATCH), 32'd0);
      check("ack_state", 32'(dut.state_q), 32'(ARMED));
      check("ack_rdy",   32'(RDY), 32'd1);
      tick();
      ACK = 1'b0;
      check("ack_armed_match", 32'(MATCH), 32'd0);
      check("ack_armed_state", 32'(dut.state_q), 32'(ARMED));
      check("ack_armed_hcnt",  32'(HCNT), 32'd2);

      // Window 0111_0000: no intermediate window has upper nibble F
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] v;
         v = 8'h70;
         SE = 1'b1; SI = v[i];
         tick();
         check("nomatch_step", 32'(MATCH), 32'd0);
      end
      SE = 1'b0;
      tick();
      check("nomatch_match", 32'(MATCH), 32'd0);
      check("nomatch_hcnt",  32'(HCNT),  32'd2);

      // Overrun: zero stream, ACK low
      CDN = 1'b0; #2; CDN = 1'b1;
      @(negedge CK);
      load(8'h00, 8'hFF);
      SE = 1'b1; SI = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (n == 8)  begin check("ovr_rdy", 32'(RDY), 32'd1); check("ovr_m8", 32'(MATCH), 32'd0); end
         if (n == 9)  begin check("ovr_m9", 32'(MATCH), 32'd1); check("ovr_h9", 32'(HCNT), 32'd1); check("ovr_o9", 32'(OVR), 32'd0); end
         if (n == 10) begin check("ovr_o10", 32'(OVR), 32'd1); check("ovr_h10", 32'(HCNT), 32'd2); end
         if (n == 15) check("ovr_h15", 32'(HCNT), 32'd7);
         if (n == 30) begin check("ovr_sat", 32'(HCNT), 32'd15); check("ovr_m30", 32'(MATCH), 32'd1); end
      end

      // Asynchronous reset between edges while in HIT
      #2;
      CDN = 1'b0;
      #1;
      check("async_match", 32'(MATCH), 32'd0);
      check("async_ovr",   32'(OVR),   32'd0);
      check("async_hcnt",  32'(HCNT),  32'd0);
      check("async_rdy",   32'(RDY),   32'd0);
      check("async_mr",    32'(dut.mr_q), 32'hFF);
      SE = 1'b0;
      CDN = 1'b1;
      @(negedge CK);

      // Back-to-back with ACK held high
      load(8'h00, 8'hFF);
      ACK = 1'b1;
      SE = 1'b1; SI = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         tick();
         if (n >= 9) begin
            check("b2b_match", 32'(MATCH), 32'd1);
            check("b2b_ovr",   32'(OVR),   32'd0);
            check("b2b_hcnt",  32'(HCNT),  32'(n - 8));
         end
      end
      SE = 1'b0;
      tick();
      check("b2b_last_match", 32'(MATCH), 32'd1);
      check("b2b_last_hcnt",  32'(HCNT),  32'd7);
      tick();
      check("b2b_rel_match", 32'(MATCH), 32'd0);
      check("b2b_rel_ovr",   32'(OVR),   32'd0);
      check("b2b_rel_hcnt",  32'(HCNT),  32'd7);
      ACK = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
